// File: rtl/tdp_ram_be_if.sv
// tdp_ram_be_if: bus bundle for the true dual-port byte-enable RAM.
// Carries both access ports, the zero-fill request/status and the
// collision flag. The master side drives requests; the slave side is the RAM.
interface tdp_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    // zero-fill control and status
    logic                  clear;
    logic                  init_busy;

    // port A
    logic                  en_a;
    logic                  we_a;
    logic [NB-1:0]         be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_in_a;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic                  valid_a;

    // port B
    logic                  en_b;
    logic                  we_b;
    logic [NB-1:0]         be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_in_b;
    logic [DATA_WIDTH-1:0] data_out_b;
    logic                  valid_b;

    // same-address dual-write collision pulse
    logic                  coll;

    modport master (
        output clear,
        output en_a, we_a, be_a, addr_a, data_in_a,
        output en_b, we_b, be_b, addr_b, data_in_b,
        input  init_busy,
        input  data_out_a, valid_a,
        input  data_out_b, valid_b,
        input  coll
    );

    modport slave (
        input  clear,
        input  en_a, we_a, be_a, addr_a, data_in_a,
        input  en_b, we_b, be_b, addr_b, data_in_b,
        output init_busy,
        output data_out_a, valid_a,
        output data_out_b, valid_b,
        output coll
    );
endinterface

// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port RAM with per-byte write enables, selectable
// same-port read-during-write behaviour, a fixed dual-write collision policy
// and an automatic zero-fill walk after reset or on a clear request.
// Optional feature macro: OUTPUT_REG_EN adds a second output register stage
// on data_out/valid of both ports and delays coll to match.
module tdp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int COLL_PRIO  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    tdp_ram_be_if.slave     bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [CW-1:0] INIT_LAST = CW'(DEPTH - 1);

    // storage: not reset, the INIT walk is what clears it
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // control state
    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         init_cnt_q, init_cnt_d;

    // first output stage
    logic [DATA_WIDTH-1:0] data_out_a_q, data_out_a_d;
    logic [DATA_WIDTH-1:0] data_out_b_q, data_out_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic                  coll_q, coll_d;

    // access decode
    logic                  ready;
    logic                  acc_a, acc_b;
    logic                  wr_a, wr_b;
    logic                  same_addr;
    logic [NB-1:0]         lane_wr_a, lane_wr_b;
    logic [NB-1:0]         overlap;
    logic [NB-1:0]         lane_we_a, lane_we_b;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] merged_a, merged_b;
    logic [DATA_WIDTH:0]   next_a, next_b;

    // Picks the registered {valid, data} for one port given its request.
    // Reads always return the stored word; writes follow RDW_MODE, where
    // mode 2 falls through to "hold data, valid low".
    function automatic logic [DATA_WIDTH:0] port_next(
        input logic                  access,
        input logic                  write,
        input logic [DATA_WIDTH-1:0] held,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] merged_word
    );
        logic [DATA_WIDTH:0] r;
        r = {1'b0, held};
        if (access) begin
            if (!write) begin
                r = {1'b1, old_word};
            end else if (RDW_MODE == 0) begin
                r = {1'b1, old_word};
            end else if (RDW_MODE == 1) begin
                r = {1'b1, merged_word};
            end
        end
        return r;
    endfunction

    // INIT walks every address once, then READY serves the ports until a clear
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Lane-level write decode; overlapping lanes at one address go to the COLL_PRIO winner
    always_comb begin
        ready     = (state_q == ST_READY);
        acc_a     = ready & bus.en_a;
        acc_b     = ready & bus.en_b;
        wr_a      = acc_a & bus.we_a;
        wr_b      = acc_b & bus.we_b;
        same_addr = (bus.addr_a == bus.addr_b);
        lane_wr_a = bus.be_a & {NB{wr_a}};
        lane_wr_b = bus.be_b & {NB{wr_b}};
        overlap   = lane_wr_a & lane_wr_b & {NB{same_addr}};
        if (COLL_PRIO == 0) begin
            lane_we_a = lane_wr_a;
            lane_we_b = lane_wr_b & ~overlap;
        end else begin
            lane_we_a = lane_wr_a & ~overlap;
            lane_we_b = lane_wr_b;
        end
        coll_d    = |overlap;
    end

    // Pre-write words and own-port merged words used for data return
    always_comb begin
        old_a    = mem[bus.addr_a];
        old_b    = mem[bus.addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (bus.be_a[i]) begin
                merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (bus.be_b[i]) begin
                merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Next output values for both ports; the other port's write is never visible here
    always_comb begin
        next_a       = port_next(acc_a, bus.we_a, data_out_a_q, old_a, merged_a);
        next_b       = port_next(acc_b, bus.we_b, data_out_b_q, old_b, merged_b);
        valid_a_d    = next_a[DATA_WIDTH];
        data_out_a_d = next_a[DATA_WIDTH-1:0];
        valid_b_d    = next_b[DATA_WIDTH];
        data_out_b_d = next_b[DATA_WIDTH-1:0];
    end

    // Array update: zero one word per cycle in INIT, byte-lane writes in READY
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[init_cnt_q[ADDR_WIDTH-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lane_we_a[i]) begin
                    mem[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (lane_we_b[i]) begin
                    mem[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Control and first output stage; reset restarts the walk from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            data_out_a_q <= '0;
            data_out_b_q <= '0;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
            coll_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            data_out_a_q <= data_out_a_d;
            data_out_b_q <= data_out_b_d;
            valid_a_q    <= valid_a_d;
            valid_b_q    <= valid_b_d;
            coll_q       <= coll_d;
        end
    end

    assign bus.init_busy = (state_q == ST_INIT);

`ifdef OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] data_out_a_r_q, data_out_a_r_d;
    logic [DATA_WIDTH-1:0] data_out_b_r_q, data_out_b_r_d;
    logic                  valid_a_r_q, valid_a_r_d;
    logic                  valid_b_r_q, valid_b_r_d;
    logic                  coll_r_q, coll_r_d;

    // Second stage simply follows the first one cycle later
    always_comb begin
        data_out_a_r_d = data_out_a_q;
        data_out_b_r_d = data_out_b_q;
        valid_a_r_d    = valid_a_q;
        valid_b_r_d    = valid_b_q;
        coll_r_d       = coll_q;
    end

    // Second output stage registers, cleared by reset like the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_a_r_q <= '0;
            data_out_b_r_q <= '0;
            valid_a_r_q    <= 1'b0;
            valid_b_r_q    <= 1'b0;
            coll_r_q       <= 1'b0;
        end else begin
            data_out_a_r_q <= data_out_a_r_d;
            data_out_b_r_q <= data_out_b_r_d;
            valid_a_r_q    <= valid_a_r_d;
            valid_b_r_q    <= valid_b_r_d;
            coll_r_q       <= coll_r_d;
        end
    end

    assign bus.data_out_a = data_out_a_r_q;
    assign bus.data_out_b = data_out_b_r_q;
    assign bus.valid_a    = valid_a_r_q;
    assign bus.valid_b    = valid_b_r_q;
    assign bus.coll       = coll_r_q;
`else
    assign bus.data_out_a = data_out_a_q;
    assign bus.data_out_b = data_out_b_q;
    assign bus.valid_a    = valid_a_q;
    assign bus.valid_b    = valid_b_q;
    assign bus.coll       = coll_q;
`endif

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb_tdp_ram_be: directed bench for tdp_ram_be. Three instances share one
// stimulus stream: read-first/A-priority, write-first/A-priority and
// no-change/B-priority. Honours OUTPUT_REG_EN by waiting the longer latency.
module tb_tdp_ram_be;
`ifdef OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tdp_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) bus0 ();
    tdp_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();
    tdp_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) bus2 ();

    tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .RDW_MODE(0), .COLL_PRIO(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .RDW_MODE(1), .COLL_PRIO(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    tdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(8), .RDW_MODE(2), .COLL_PRIO(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // mirror the request side of bus0 onto the other two instances
    assign bus1.clear = bus0.clear;      assign bus2.clear = bus0.clear;
    assign bus1.en_a = bus0.en_a;        assign bus2.en_a = bus0.en_a;
    assign bus1.we_a = bus0.we_a;        assign bus2.we_a = bus0.we_a;
    assign bus1.be_a = bus0.be_a;        assign bus2.be_a = bus0.be_a;
    assign bus1.addr_a = bus0.addr_a;    assign bus2.addr_a = bus0.addr_a;
    assign bus1.data_in_a = bus0.data_in_a; assign bus2.data_in_a = bus0.data_in_a;
    assign bus1.en_b = bus0.en_b;        assign bus2.en_b = bus0.en_b;
    assign bus1.we_b = bus0.we_b;        assign bus2.we_b = bus0.we_b;
    assign bus1.be_b = bus0.be_b;        assign bus2.be_b = bus0.be_b;
    assign bus1.addr_b = bus0.addr_b;    assign bus2.addr_b = bus0.addr_b;
    assign bus1.data_in_b = bus0.data_in_b; assign bus2.data_in_b = bus0.data_in_b;

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // safety net in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus0.clear = 1'b0;
        bus0.en_a = 1'b0; bus0.we_a = 1'b0; bus0.be_a = 4'h0; bus0.addr_a = 8'h00; bus0.data_in_a = 32'h0;
        bus0.en_b = 1'b0; bus0.we_b = 1'b0; bus0.be_b = 4'h0; bus0.addr_b = 8'h00; bus0.data_in_b = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // one access cycle on both ports, then idle until the result is visible
    task automatic applyStimulus(
        input logic en_a, input logic we_a, input logic [3:0] be_a, input logic [7:0] addr_a, input logic [31:0] din_a,
        input logic en_b, input logic we_b, input logic [3:0] be_b, input logic [7:0] addr_b, input logic [31:0] din_b
    );
        bus0.en_a = en_a; bus0.we_a = we_a; bus0.be_a = be_a; bus0.addr_a = addr_a; bus0.data_in_a = din_a;
        bus0.en_b = en_b; bus0.we_b = we_b; bus0.be_b = be_b; bus0.addr_b = addr_b; bus0.data_in_b = din_b;
        tick();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic writeA(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        applyStimulus(1'b1, 1'b1, be, addr, data, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic readA(input logic [7:0] addr);
        applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic readB(input logic [7:0] addr);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, addr, 32'h0);
    endtask

    // count cycles until init_busy drops, bounded
    task automatic waitInit(input string tag, input int start);
        int n;
        n = start;
        while (bus0.init_busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, n, 256);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        repeat (3) tick();

        // reset values
        checkOutput("rst_init_busy", bus0.init_busy, 1);
        checkOutput("rst_dout_a", bus0.data_out_a, 0);
        checkOutput("rst_dout_b", bus0.data_out_b, 0);
        checkOutput("rst_valid_a", bus0.valid_a, 0);
        checkOutput("rst_valid_b", bus0.valid_b, 0);
        checkOutput("rst_coll", bus0.coll, 0);

        // zero-fill after reset lasts one cycle per word
        rst_n = 1'b1;
        waitInit("init_len_reset", 0);

        readA(8'd0);
        checkOutput("init_rd0_data", bus0.data_out_a, 32'h0);
        checkOutput("init_rd0_valid", bus0.valid_a, 1);
        readB(8'd128);
        checkOutput("init_rd128_data", bus0.data_out_b, 32'h0);
        checkOutput("init_rd128_valid", bus0.valid_b, 1);
        readA(8'd255);
        checkOutput("init_rd255_data", bus0.data_out_a, 32'h0);
        checkOutput("init_rd255_valid", bus0.valid_a, 1);

        // byte enables
        writeA(8'h10, 32'hAABBCCDD, 4'hF);
        writeA(8'h10, 32'h11223344, 4'h5);
        checkOutput("be_rdw0_old", bus0.data_out_a, 32'hAABBCCDD);
        checkOutput("be_rdw0_valid", bus0.valid_a, 1);
        checkOutput("be_rdw1_merged", bus1.data_out_a, 32'hAA22CC44);
        readB(8'h10);
        checkOutput("be_merge_read", bus0.data_out_b, 32'hAA22CC44);
        checkOutput("be_merge_valid", bus0.valid_b, 1);

        // read latency
        bus0.en_a = 1'b1; bus0.we_a = 1'b0; bus0.addr_a = 8'h10;
        tick();
        idle();
        checkOutput("lat_valid_edge1", bus0.valid_a, (LAT == 1) ? 1 : 0);
        tick();
        checkOutput("lat_valid_edge2", bus0.valid_a, (LAT == 2) ? 1 : 0);
        checkOutput("lat_data", bus0.data_out_a, 32'hAA22CC44);

        // same-port read-during-write modes
        writeA(8'h20, 32'h5, 4'hF);
        writeA(8'h20, 32'h9, 4'hF);
        checkOutput("rdw0_data", bus0.data_out_a, 32'h5);
        checkOutput("rdw0_valid", bus0.valid_a, 1);
        checkOutput("rdw1_data", bus1.data_out_a, 32'h9);
        checkOutput("rdw1_valid", bus1.valid_a, 1);
        checkOutput("rdw2_data_hold", bus2.data_out_a, 32'hAA22CC44);
        checkOutput("rdw2_valid", bus2.valid_a, 0);

        // dual write, overlapping lane 1
        applyStimulus(1'b1, 1'b1, 4'h3, 8'h30, 32'h11111111, 1'b1, 1'b1, 4'h6, 8'h30, 32'h22222222);
        checkOutput("coll_pulse_a_prio", bus0.coll, 1);
        checkOutput("coll_pulse_b_prio", bus2.coll, 1);
        tick();
        checkOutput("coll_one_cycle", bus0.coll, 0);
        readA(8'h30);
        checkOutput("coll_data_a_prio", bus0.data_out_a, 32'h00221111);
        checkOutput("coll_data_b_prio", bus2.data_out_a, 32'h00222211);

        // dual write, disjoint lanes
        applyStimulus(1'b1, 1'b1, 4'h1, 8'h31, 32'h11111111, 1'b1, 1'b1, 4'h2, 8'h31, 32'h22222222);
        checkOutput("nocoll_flag", bus0.coll, 0);
        readB(8'h31);
        checkOutput("nocoll_data", bus0.data_out_b, 32'h00002211);

        // cross-port write/read of one address
        writeA(8'h40, 32'h7, 4'hF);
        applyStimulus(1'b1, 1'b1, 4'hF, 8'h40, 32'h8, 1'b1, 1'b0, 4'h0, 8'h40, 32'h0);
        checkOutput("xport_old_rdw0", bus0.data_out_b, 32'h7);
        checkOutput("xport_old_rdw1", bus1.data_out_b, 32'h7);
        checkOutput("xport_valid", bus0.valid_b, 1);
        readB(8'h40);
        checkOutput("xport_new", bus0.data_out_b, 32'h8);

        // dual read, then hold with en low
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h40, 32'h0, 1'b1, 1'b0, 4'h0, 8'h40, 32'h0);
        checkOutput("dualrd_a", bus0.data_out_a, 32'h8);
        checkOutput("dualrd_b", bus0.data_out_b, 32'h8);
        tick();
        checkOutput("hold_data", bus0.data_out_b, 32'h8);
        checkOutput("hold_valid", bus0.valid_b, 0);

        // clear, with a read serviced in the same cycle
        bus0.clear = 1'b1;
        bus0.en_b = 1'b1; bus0.we_b = 1'b0; bus0.addr_b = 8'h40;
        tick();
        idle();
        checkOutput("clear_busy", bus0.init_busy, 1);
        repeat (LAT - 1) tick();
        checkOutput("clear_same_cycle_data", bus0.data_out_b, 32'h8);
        checkOutput("clear_same_cycle_valid", bus0.valid_b, 1);
        waitInit("init_len_clear", LAT - 1);
        readB(8'h10);
        checkOutput("clear_zero_10", bus0.data_out_b, 32'h0);
        readB(8'h40);
        checkOutput("clear_zero_40", bus0.data_out_b, 32'h0);
        checkOutput("clear_zero_valid", bus0.valid_b, 1);

        // reset mid-INIT, with an ignored read during the walk
        bus0.clear = 1'b1;
        tick();
        idle();
        repeat (50) tick();
        bus0.en_a = 1'b1; bus0.we_a = 1'b0; bus0.addr_a = 8'h10;
        tick();
        idle();
        repeat (LAT - 1) tick();
        checkOutput("init_read_ignored_valid", bus0.valid_a, 0);
        checkOutput("init_read_hold_data", bus0.data_out_a, 32'h8);
        repeat (50 - LAT) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midinit_rst_dout", bus0.data_out_a, 0);
        checkOutput("midinit_rst_busy", bus0.init_busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        waitInit("init_len_restart", 0);
        readA(8'h40);
        checkOutput("restart_read_data", bus0.data_out_a, 32'h0);
        checkOutput("restart_read_valid", bus0.valid_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
